// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: loads an operand into shift_reg, then drives one serial shift per cycle.
// Optional abort input when SHIFT_ABORT_EN is defined.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
`ifdef SHIFT_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_reset,
  output logic             sr_ps,
  output logic             sr_rl,
  output logic             sr_serial_left,
  output logic             sr_serial_right,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] amount_q, amount_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             abort_w;

`ifdef SHIFT_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      amount_q <= '0;
      data_q   <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      amount_q <= amount_d;
      data_q   <= data_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    amount_d = amount_q;
    data_d   = data_q;
    count_d  = count_q;
    carry_d  = carry_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          amount_d = amount;
          data_d   = data_in;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = amount_q;
        if (amount_q == '0) begin
          carry_d = carry_in;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        count_d = count_q - CNT_ONE;
        // Left shifts lose the MSB; every right-going op loses the LSB.
        carry_d = (op_q == OP_LSL) ? sr_q[WIDTH-1] : sr_q[0];
        if (count_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_w && (state_q == S_LOAD || state_q == S_SHIFT)) begin
      state_d = S_IDLE;
      count_d = count_q;
      carry_d = carry_q;
    end
  end

  always_comb begin
    sr_ps           = 1'b1;
    sr_data         = sr_q;
    sr_rl           = 1'b0;
    sr_serial_left  = 1'b0;
    sr_serial_right = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        sr_data = data_q;
      end
      S_SHIFT: begin
        sr_ps = 1'b0;
        unique case (op_q)
          OP_LSL: begin
            sr_rl           = 1'b0;
            sr_serial_right = 1'b0;
          end
          OP_LSR: begin
            sr_rl          = 1'b1;
            sr_serial_left = 1'b0;
          end
          OP_ASR: begin
            sr_rl          = 1'b1;
            sr_serial_left = sr_q[WIDTH-1];
          end
          OP_ROR: begin
            sr_rl          = 1'b1;
            sr_serial_left = sr_q[0];
          end
          default: begin
            sr_rl = 1'b0;
          end
        endcase
      end
      default: begin
        sr_ps = 1'b1;
      end
    endcase
  end

  assign sr_reset  = ~reset;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = sr_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural shift_reg load.
// Scoreboard of expected results; monitor pops on done.
module tb_shift_seq_ctrl;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [CW-1:0] amount;
  logic [W-1:0]  data_in;
  logic          carry_in;
`ifdef SHIFT_ABORT_EN
  logic          abort;
`endif
  logic [W-1:0]  sr_q;
  logic [W-1:0]  sr_data;
  logic          sr_reset;
  logic          sr_ps;
  logic          sr_rl;
  logic          sr_serial_left;
  logic          sr_serial_right;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry_out;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cyc;
  bit   hold_valid;
  logic [W-1:0] hold_val;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .amount(amount),
    .data_in(data_in),
    .carry_in(carry_in),
`ifdef SHIFT_ABORT_EN
    .abort(abort),
`endif
    .sr_q(sr_q),
    .sr_data(sr_data),
    .sr_reset(sr_reset),
    .sr_ps(sr_ps),
    .sr_rl(sr_rl),
    .sr_serial_left(sr_serial_left),
    .sr_serial_right(sr_serial_right),
    .busy(busy),
    .done(done),
    .result(result),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // shift_reg load model
  always @(posedge clk) begin
    if (sr_reset) sr_q <= '0;
    else if (sr_ps) sr_q <= sr_data;
    else if (sr_rl) sr_q <= {sr_serial_left, sr_q[W-1:1]};
    else sr_q <= {sr_q[W-2:0], sr_serial_right};
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [1:0] o, int n,
                                 logic [W-1:0] x, logic cin);
    exp_t e;
    logic [2*W-1:0] d;
    logic [W-1:0] r;
    e.cyc = 0;
    if (n == 0) begin
      e.res  = x;
      e.cout = cin;
      return e;
    end
    case (o)
      2'd0: begin
        r = x << n;
        e.cout = x[W-n];
      end
      2'd1: begin
        r = x >> n;
        e.cout = x[n-1];
      end
      2'd2: begin
        r = $signed(x) >>> n;
        e.cout = x[n-1];
      end
      default: begin
        d = {x, x} >> n;
        r = d[W-1:0];
        e.cout = x[n-1];
      end
    endcase
    e.res = r;
    return e;
  endfunction

  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", int'(result), int'(e.res));
          chk("carry_out", int'(carry_out), int'(e.cout));
          chk("done_cycle", cyc, e.cyc);
          hold_val   = e.res;
          hold_valid = 1'b1;
        end
      end else if (!busy && hold_valid) begin
        chk("result_hold", int'(result), int'(hold_val));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(logic [1:0] o, int n, logic [W-1:0] x,
                       logic cin, bit junk);
    exp_t e;
    wait_idle();
    op       = o;
    amount   = CW'(n);
    data_in  = x;
    carry_in = cin;
    start    = 1'b1;
    e = model(o, n, x, cin);
    e.cyc = cyc + n + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (junk) begin
      for (int i = 0; i < 20; i++) begin
        if (!busy) break;
        start   = 1'($urandom_range(0, 1));
        op      = 2'($urandom);
        amount  = CW'($urandom);
        data_in = W'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end
  endtask

  initial begin
    logic c;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    hold_valid = 1'b0;
    hold_val   = '0;
    reset      = 1'b0;
    start      = 1'b0;
    op         = '0;
    amount     = '0;
    data_in    = '0;
    carry_in   = 1'b0;
`ifdef SHIFT_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_carry", int'(carry_out), 0);
    chk("rst_sr_reset", int'(sr_reset), 1);
    chk("rst_result", int'(result), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("sr_reset_off", int'(sr_reset), 0);

    issue(2'd0, 3, 8'b1001_0110, 1'b0, 1'b0);
    issue(2'd2, 2, 8'b1000_0001, 1'b0, 1'b0);
    issue(2'd3, 1, 8'b1000_0001, 1'b0, 1'b0);
    issue(2'd0, 0, 8'hA5, 1'b1, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);
    issue(2'd1, 5, 8'hF3, 1'b0, 1'b1);
    issue(2'd2, 7, 8'h9C, 1'b1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      issue(2'($urandom), int'($urandom_range(0, 7)),
            W'($urandom), 1'($urandom),
            bit'($urandom_range(0, 1)));
    end

    wait_idle();
    issue(2'd1, 5, 8'h5A, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    hold_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_carry", int'(carry_out), 0);
    reset = 1'b1;
    issue(2'd3, 4, 8'h3C, 1'b0, 1'b0);

`ifdef SHIFT_ABORT_EN
    wait_idle();
    issue(2'd0, 6, 8'hE7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    sb.delete();
    hold_valid = 1'b0;
    c = carry_out;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_carry", int'(carry_out), int'(c));
    @(negedge clk);
    chk("abort_nodone", int'(done), 0);
    issue(2'd2, 3, 8'h81, 1'b0, 1'b0);
`else
    c = 1'b0;
`endif

    wait_idle();
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
